// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the uart transmitter and receiver paths.
//   uart_state_e : frame state machine encoding (IDLE, START, DATA, PARITY, STOP)
//   DATA_BITS    : payload bits per frame
//   baud_div()   : clock cycles per line bit, truncated CLK_FREQ/BAUD
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte handoff from a byte source to the transmitter.
//   tx_data  : byte to send, sampled on accept
//   tx_valid : source has a byte
//   tx_ready : transmitter can accept (accept = tx_valid && tx_ready at clk edge)
// master = byte source, slave = transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, counts 0..DIV-1 and wraps.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count back to 0 (state change / idle)
//   bit_end    : high on terminal count DIV-1
module uart_baud_cnt #(
  parameter int DIV = 5208
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);
  localparam int             W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]   LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clear || bit_end) cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end

  assign bit_end = (cnt == LAST);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 uart transmitter (8E1/8O1 when UART_TX_PARITY_EN is defined).
//   clk, rst_n : system clock, asynchronous active-low reset
//   tx         : uart_tx_if.slave byte handoff (tx_data, tx_valid, tx_ready)
//   tx_busy    : frame in progress (state != IDLE)
//   tx_done    : one-cycle pulse once the stop bit has completed
//   rs232_tx   : registered serial line, idle high
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit after the
// data bits; PARITY_ODD selects odd (1) or even (0) parity.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int PARITY_ODD = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_tx_if.slave  tx,
  output logic      tx_busy,
  output logic      tx_done,
  output logic      rs232_tx
);
  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  uart_state_e          state, state_nxt;
  logic [2:0]           idx, idx_nxt;
  logic [DATA_BITS-1:0] data_q;
  logic                 ready_q;
  logic                 line_nxt;
  logic                 bit_end;
  logic                 clear;
  logic                 accept;

  assign accept      = tx.tx_valid && ready_q;
  assign tx.tx_ready = ready_q;
  assign tx_busy     = (state != IDLE);

  // Counter restarts on every state change; inside DATA it wraps on its own.
  assign clear = (state == IDLE) || (state_nxt != state);

  uart_baud_cnt #(.DIV(BAUD_DIV)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .bit_end (bit_end)
  );

`ifdef UART_TX_PARITY_EN
  logic par_bit;
  assign par_bit = (^data_q) ^ (PARITY_ODD != 0);
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    line_nxt  = 1'b1;
    case (state)
      IDLE:  if (accept) begin
               state_nxt = START;
               idx_nxt   = '0;
             end
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end) begin
               if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                 state_nxt = PARITY;
`else
                 state_nxt = STOP;
`endif
               end else begin
                 idx_nxt = idx + 3'd1;
               end
             end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_nxt = STOP;
`endif
      STOP:  if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Line value follows the state being entered so the registered output
    // changes on the same edge as the state register.
    case (state_nxt)
      START:   line_nxt = 1'b0;
      DATA:    line_nxt = data_q[idx_nxt];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_nxt = par_bit;
`endif
      default: line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      tx_done  <= 1'b0;
      rs232_tx <= 1'b1;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      ready_q  <= (state_nxt == IDLE);
      tx_done  <= (state == STOP) && bit_end;
      rs232_tx <= line_nxt;
      if (accept) data_q <= tx.tx_data;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx at a shortened bit
// period (BAUD_DIV = 10). Frames are checked bit by bit: each bit must hold
// its expected level for exactly DIV cycles.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 5_000_000;
  localparam int DIV      = 10;
  localparam int PODD     = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_busy, tx_done, rs232_tx;

  uart_tx_if txi ();

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_ODD(PODD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx       (txi),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .rs232_tx (rs232_tx)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line levels, index 0 = start bit.
  function automatic logic [NB-1:0] frame_bits(input logic [7:0] d);
    logic [NB-1:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = (^d) ^ (PODD != 0);
`endif
    return f;
  endfunction

  // Called just after the accept edge. Optionally changes the source
  // signals at the start of bit 4 to probe the latched copy / back-to-back.
  task automatic check_frame(input string tag, input logic [7:0] d,
                             input logic mid_en, input logic [7:0] mid_d,
                             input logic mid_v);
    logic [NB-1:0] f;
    int good, done_seen, rdy_bad, busy_bad;
    f = frame_bits(d);
    done_seen = 0; rdy_bad = 0; busy_bad = 0;
    for (int b = 0; b < NB; b++) begin
      good = 0;
      for (int c = 0; c < DIV; c++) begin
        @(negedge clk);
        if (rs232_tx === f[b]) good++;
        if (tx_done)  done_seen++;
        if (tx_ready_w()) rdy_bad++;
        if (!tx_busy) busy_bad++;
        if (mid_en && b == 4 && c == 0) begin
          txi.tx_data  = mid_d;
          txi.tx_valid = mid_v;
        end
      end
      chk($sformatf("%s_bit%0d", tag, b), good, DIV);
    end
    chk({tag, "_done_early"}, done_seen, 0);
    chk({tag, "_ready_in_frame"}, rdy_bad, 0);
    chk({tag, "_busy_drop"}, busy_bad, 0);
    @(negedge clk);
    chk({tag, "_done"}, tx_done, 1);
    chk({tag, "_ready_end"}, txi.tx_ready, 1);
    chk({tag, "_busy_end"}, tx_busy, 0);
    chk({tag, "_line_end"}, rs232_tx, 1);
  endtask

  function automatic logic tx_ready_w();
    return txi.tx_ready;
  endfunction

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    txi.tx_data  = d;
    txi.tx_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hi, dn;
    txi.tx_valid = 1'b0;
    txi.tx_data  = 8'h00;

    // Reset
    #50;
    chk("rst_line", rs232_tx, 1);
    chk("rst_ready", txi.tx_ready, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    #150;
    rst_n = 1'b1;
    #1;
    chk("rel_ready_pre", txi.tx_ready, 0);
    @(negedge clk);
    chk("rel_ready", txi.tx_ready, 1);

    // Idle with tx_valid low
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (rs232_tx === 1'b1 && !tx_busy) hi++;
    end
    chk("idle_line", hi, 20);

    // Single byte 0xA5
    send(8'hA5);
    txi.tx_valid = 1'b0;
    check_frame("a5", 8'hA5, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("a5_done_pulse", tx_done, 0);

    // Back-to-back 0x00 then 0xFF
    send(8'h00);
    check_frame("b2b0", 8'h00, 1'b1, 8'hFF, 1'b1);
    @(posedge clk);
    #1;
    check_frame("b2b1", 8'hFF, 1'b1, 8'hFF, 1'b0);
    @(negedge clk);
    chk("b2b_done_pulse", tx_done, 0);

    // 0x3C accepted, 0xC3 driven while busy
    send(8'h3C);
    txi.tx_data = 8'hC3;
    check_frame("tog", 8'h3C, 1'b1, 8'hC3, 1'b0);

`ifdef UART_TX_PARITY_EN
    send(8'h07);
    txi.tx_valid = 1'b0;
    check_frame("p07", 8'h07, 1'b0, 8'h00, 1'b0);
`endif

    // Reset during data bit 3 (frame bit 4); 0xF0 has bit 3 = 0
    send(8'hF0);
    txi.tx_valid = 1'b0;
    repeat (4 * DIV + DIV / 2) @(negedge clk);
    chk("mid_pre_line", rs232_tx, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_line", rs232_tx, 1);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_ready", txi.tx_ready, 0);
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_done) dn++;
    end
    rst_n = 1'b1;
    repeat (2 * DIV) begin
      @(negedge clk);
      if (tx_done) dn++;
    end
    chk("mid_rst_no_done", dn, 0);
    chk("mid_rel_ready", txi.tx_ready, 1);
    send(8'h55);
    txi.tx_valid = 1'b0;
    check_frame("post55", 8'h55, 1'b0, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
